// File: rtl/mm_trace_pkg.sv
// mm_trace_pkg: widths and field offsets of a trace entry; ENTRY_W grows to 64 bits when MM_TRACE_STAMP_EN is defined.
package mm_trace_pkg;
    localparam int INSTR_W   = 16;
    localparam int RESULT_W  = 32;
    localparam int STAMP_W   = 16;
`ifdef MM_TRACE_STAMP_EN
    localparam int ENTRY_W   = RESULT_W + INSTR_W + STAMP_W;
`else
    localparam int ENTRY_W   = RESULT_W + INSTR_W;
`endif
    localparam int RESULT_LSB = 0;
    localparam int INSTR_LSB  = RESULT_LSB + RESULT_W;
    localparam int STAMP_LSB  = INSTR_LSB + INSTR_W;
endpackage

// File: rtl/mm_trace_mem.sv
// mm_trace_mem: DEPTH x W storage with one synchronous write port and one asynchronous read port.
module mm_trace_mem #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int W      = 48
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [W-1:0]      i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [W-1:0]      o_rdata
);
    logic [W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk)
        if (i_we) r_mem[i_waddr] <= i_wdata;

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/mm_trace_buffer.sv
// mm_trace_buffer: circular capture FIFO for MiniMIPS instruction/result pairs with show-ahead read and saturating overflow count.
// Define MM_TRACE_STAMP_EN to store a 16-bit cycle stamp with each entry and expose it on rd_stamp.
module mm_trace_buffer
    import mm_trace_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int OVF_W  = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cap_en,
    input  logic [INSTR_W-1:0]  instruction,
    input  logic [RESULT_W-1:0] result,
    input  logic                rd_ready,
    output logic                rd_valid,
    output logic [INSTR_W-1:0]  rd_instruction,
    output logic [RESULT_W-1:0] rd_result,
`ifdef MM_TRACE_STAMP_EN
    output logic [STAMP_W-1:0]  rd_stamp,
`endif
    output logic [ADDR_W:0]     count,
    output logic                full,
    output logic                empty,
    output logic [OVF_W-1:0]    overflow_cnt
);
    logic [ADDR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic [OVF_W-1:0]  r_ovf;
    logic              w_push, w_pop, w_drop;
    logic [ENTRY_W-1:0] w_wdata, w_rdata;

    assign empty    = r_count == '0;
    assign full     = r_count == (ADDR_W+1)'(DEPTH);
    assign rd_valid = ~empty;
    assign w_pop    = rd_valid & rd_ready;
    assign w_push   = cap_en & (~full | w_pop);
    assign w_drop   = cap_en & full & ~w_pop;

`ifdef MM_TRACE_STAMP_EN
    logic [STAMP_W-1:0] r_stamp;

    always_ff @(posedge clk or posedge reset)
        if (reset) r_stamp <= '0;
        else       r_stamp <= r_stamp + STAMP_W'(1);

    assign w_wdata  = {r_stamp, instruction, result};
    assign rd_stamp = empty ? '0 : w_rdata[STAMP_LSB +: STAMP_W];
`else
    assign w_wdata  = {instruction, result};
`endif

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            if (w_push & ~w_pop)      r_count <= r_count + (ADDR_W+1)'(1);
            else if (w_pop & ~w_push) r_count <= r_count - (ADDR_W+1)'(1);
            // Saturate so a long-stalled reader never sees the counter wrap back to small values
            if (w_drop & ~&r_ovf) r_ovf <= r_ovf + OVF_W'(1);
        end

    mm_trace_mem #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .W(ENTRY_W)) u_mem (
        .clk    (clk),
        .i_we   (w_push),
        .i_waddr(r_wr_ptr),
        .i_wdata(w_wdata),
        .i_raddr(r_rd_ptr),
        .o_rdata(w_rdata)
    );

    assign rd_instruction = empty ? '0 : w_rdata[INSTR_LSB +: INSTR_W];
    assign rd_result      = empty ? '0 : w_rdata[RESULT_LSB +: RESULT_W];
    assign count          = r_count;
    assign overflow_cnt   = r_ovf;
endmodule
